// File: rtl/cia_pkg.sv
// Shared CIA types.
//   reg4_t   - register address
//   reg8_t   - bus data byte
//   reg16_t  - timer latch / counter word
//   tctrl_t  - per-timer control bundle from the control-register block
package cia;

  typedef logic [3:0]  reg4_t;
  typedef logic [7:0]  reg8_t;
  typedef logic [15:0] reg16_t;

  typedef struct packed {
    logic start;
    logic toggle;
    logic one_shot;
    logic force_load;
    logic count;
  } tctrl_t;

  // Latch and counter both come out of reset at all-ones.
  localparam reg16_t TimerResetVal = 16'hFFFF;

endpackage

// File: rtl/cia_timer.sv
// CIA interval timer (used for both TIMER A and TIMER B).
// Owns the 16-bit latch, the down-counter and TxLO/TxHI write decoding.
// Ports:
//   clk      - system clock, all state on posedge
//   res_n    - synchronous active-low reset, not qualified by phi2_dn
//   phi2_dn  - one-clk strobe marking the CIA cycle boundary
//   we/addr/data - bus write; TxLO at ADDR_LO, TxHI at ADDR_LO+1
//   ctrl     - control bundle {start, toggle, one_shot, force_load, count}
//   regs     - current counter value for TxLO/TxHI reads
//   ufl      - combinational underflow for the current CIA cycle
//   tint     - registered underflow pulse, one CIA cycle wide
//   pb_out   - PB6/PB7 timer output (toggle flip-flop or pulse)
module cia_timer
  import cia::*;
#(
  parameter reg4_t ADDR_LO = 4'h4
) (
  input  logic   clk,
  input  logic   res_n,
  input  logic   phi2_dn,
  input  logic   we,
  input  reg4_t  addr,
  input  reg8_t  data,
  input  tctrl_t ctrl,
  output reg16_t regs,
  output logic   ufl,
  output logic   tint,
  output logic   pb_out
);

  localparam reg4_t AddrHi = ADDR_LO + 4'd1;

  reg16_t latch;
  reg16_t latch_next;
  reg16_t counter;
  logic   count_d;
  logic   tff;
  logic   start_prev;
  logic   lo_wr;
  logic   hi_wr;
  logic   load;

  // One-shot stop is handled by the control block through ufl.
  logic unused_one_shot;
  assign unused_one_shot = ctrl.one_shot;

  assign lo_wr = we && (addr == ADDR_LO);
  assign hi_wr = we && (addr == AddrHi);

  // Loads always see this cycle's write so a write and its load coincide.
  always_comb begin
    latch_next = latch;
    if (lo_wr) latch_next[7:0]  = data;
    if (hi_wr) latch_next[15:8] = data;
  end

  assign ufl  = count_d && (counter == 16'h0000);
  // A TxHI write loads only while the timer is stopped.
  assign load = ufl || ctrl.force_load || (hi_wr && !ctrl.start);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      latch      <= TimerResetVal;
      counter    <= TimerResetVal;
      count_d    <= 1'b0;
      tint       <= 1'b0;
      tff        <= 1'b0;
      start_prev <= 1'b0;
    end else if (phi2_dn) begin
      latch      <= latch_next;
      count_d    <= ctrl.count;
      tint       <= ufl;
      start_prev <= ctrl.start;

      if (load) begin
        counter <= latch_next;
      end else if (count_d) begin
        counter <= counter - 16'd1;
      end

      // Start rise wins over a coincident underflow.
      if (ctrl.start && !start_prev) begin
        tff <= 1'b1;
      end else if (ufl) begin
        tff <= ~tff;
      end
    end
  end

  assign regs   = counter;
  assign pb_out = ctrl.toggle ? tff : tint;

endmodule

// File: tb/tb_cia_timer.sv
module tb_cia_timer;
  import cia::*;

  logic   clk = 1'b0;
  logic   res_n = 1'b1;
  logic   phi2_dn = 1'b0;
  logic   we = 1'b0;
  reg4_t  addr = 4'h0;
  reg8_t  data = 8'h00;
  tctrl_t ctrl = '0;
  reg16_t regs;
  logic   ufl;
  logic   tint;
  logic   pb_out;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [15:0] m_latch, m_cnt;
  logic        m_cd, m_tint, m_tff, m_sp;
  logic        m_ufl_pre;
  logic        ufl_obs;

  cia_timer #(.ADDR_LO(4'h4)) dut (
    .clk    (clk),
    .res_n  (res_n),
    .phi2_dn(phi2_dn),
    .we     (we),
    .addr   (addr),
    .data   (data),
    .ctrl   (ctrl),
    .regs   (regs),
    .ufl    (ufl),
    .tint   (tint),
    .pb_out (pb_out)
  );

  always #5 clk = ~clk;

  function automatic tctrl_t mk(input logic st, input logic tg, input logic fl, input logic cn);
    tctrl_t c;
    c.start = st; c.toggle = tg; c.one_shot = 1'b0; c.force_load = fl; c.count = cn;
    return c;
  endfunction

  // One clk: drive at negedge, sample ufl before the edge, advance model, settle after edge.
  task automatic step(input logic rn, input logic phi, input logic w, input logic [3:0] a,
                      input logic [7:0] d, input tctrl_t c);
    logic [15:0] ln;
    logic        u, ld;
    @(negedge clk);
    res_n = rn; phi2_dn = phi; we = w; addr = a; data = d; ctrl = c;
    #1;
    ufl_obs   = ufl;
    m_ufl_pre = m_cd && (m_cnt == 16'h0000);
    @(posedge clk);
    if (!rn) begin
      m_latch = 16'hFFFF; m_cnt = 16'hFFFF;
      m_cd = 0; m_tint = 0; m_tff = 0; m_sp = 0;
    end else if (phi) begin
      ln = m_latch;
      if (w && a == 4'd4) ln = {ln[15:8], d};
      if (w && a == 4'd5) ln = {d, ln[7:0]};
      u  = m_ufl_pre;
      ld = u || c.force_load || (w && a == 4'd5 && !c.start);
      if (ld) m_cnt = ln;
      else if (m_cd) m_cnt = m_cnt - 16'd1;
      if (c.start && !m_sp) m_tff = 1'b1;
      else if (u) m_tff = ~m_tff;
      m_sp = c.start; m_cd = c.count; m_tint = u; m_latch = ln;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, mk(0, 0, 0, 0));
    checks++;
    if (regs !== 16'hFFFF) begin errors++; $display("FAIL reset_regs got %h want ffff", regs); end
    checks++;
    if (tint !== 1'b0) begin errors++; $display("FAIL reset_tint got %b want 0", tint); end
    checks++;
    if (pb_out !== 1'b0) begin errors++; $display("FAIL reset_pb got %b want 0", pb_out); end
    checks++;
    if (ufl !== 1'b0) begin errors++; $display("FAIL reset_ufl got %b want 0", ufl); end
  endtask

  task automatic test_stopped_load();
    step(1, 1, 1, 4'h4, 8'h03, mk(0, 0, 0, 0));
    checks++;
    if (regs !== 16'hFFFF) begin errors++; $display("FAIL lo_no_load got %h want ffff", regs); end
    step(1, 1, 1, 4'h5, 8'h00, mk(0, 0, 0, 0));
    checks++;
    if (regs !== 16'h0003) begin errors++; $display("FAIL hi_load got %h want 0003", regs); end
    step(1, 1, 1, 4'h5, 8'h12, mk(1, 0, 0, 0));
    checks++;
    if (regs !== 16'h0003) begin errors++; $display("FAIL hi_running got %h want 0003", regs); end
    // Latch must now hold 1203: a force load exposes it.
    step(1, 1, 0, 4'h0, 8'h00, mk(1, 0, 1, 0));
    checks++;
    if (regs !== 16'h1203) begin errors++; $display("FAIL latch_kept got %h want 1203", regs); end
    // Strobe low: writes and loads are ignored.
    step(1, 0, 1, 4'h5, 8'h00, mk(0, 0, 1, 1));
    checks++;
    if (regs !== 16'h1203) begin errors++; $display("FAIL no_strobe got %h want 1203", regs); end
  endtask

  task automatic test_continuous();
    logic [15:0] exp_seq [9] = '{16'h3, 16'h2, 16'h1, 16'h0, 16'h3, 16'h2, 16'h1, 16'h0, 16'h3};
    step(1, 1, 1, 4'h4, 8'h03, mk(0, 0, 0, 0));
    step(1, 1, 1, 4'h5, 8'h00, mk(0, 0, 0, 0));
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 0, 4'h0, 8'h00, mk(1, 0, 0, 1));
      checks++;
      if (regs !== exp_seq[i]) begin
        errors++; $display("FAIL cont_regs step %0d got %h want %h", i, regs, exp_seq[i]);
      end
      checks++;
      if (ufl_obs !== m_ufl_pre) begin
        errors++; $display("FAIL cont_ufl step %0d got %b want %b", i, ufl_obs, m_ufl_pre);
      end
      checks++;
      if (tint !== m_tint) begin
        errors++; $display("FAIL cont_tint step %0d got %b want %b", i, tint, m_tint);
      end
    end
  endtask

  task automatic test_toggle();
    step(1, 1, 1, 4'h4, 8'h03, mk(0, 1, 0, 0));
    step(1, 1, 1, 4'h5, 8'h00, mk(0, 1, 0, 0));
    step(1, 1, 0, 4'h0, 8'h00, mk(1, 1, 0, 1));
    checks++;
    if (pb_out !== 1'b1) begin errors++; $display("FAIL toggle_set got %b want 1", pb_out); end
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, 4'h0, 8'h00, mk(1, 1, 0, 1));
      checks++;
      if (pb_out !== m_tff) begin
        errors++; $display("FAIL toggle_pb step %0d got %b want %b", i, pb_out, m_tff);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 4'h0, 8'h00, mk(1, 0, 0, 1));
      checks++;
      if (pb_out !== m_tint) begin
        errors++; $display("FAIL pulse_pb step %0d got %b want %b", i, pb_out, m_tint);
      end
    end
  endtask

  task automatic test_force_load();
    bit found;
    step(1, 1, 1, 4'h4, 8'h10, mk(1, 0, 0, 1));
    step(1, 1, 1, 4'h5, 8'h00, mk(1, 0, 0, 1));
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1, 1, 0, 4'h0, 8'h00, mk(1, 0, 0, 1));
      if (m_cnt == 16'h0002 && m_cd) found = 1;
    end
    checks++;
    if (!found || regs !== 16'h0002) begin
      errors++; $display("FAIL fl_reach2 got %h want 0002", regs);
    end
    step(1, 1, 0, 4'h0, 8'h00, mk(1, 0, 1, 1));
    checks++;
    if (regs !== 16'h0010) begin errors++; $display("FAIL fl_mid got %h want 0010", regs); end
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1, 1, 0, 4'h0, 8'h00, mk(1, 0, 0, 1));
      if (m_cnt == 16'h0000 && m_cd) found = 1;
    end
    step(1, 1, 0, 4'h0, 8'h00, mk(1, 0, 1, 1));
    checks++;
    if (!found || ufl_obs !== 1'b1) begin
      errors++; $display("FAIL fl_ufl got %b want 1", ufl_obs);
    end
    checks++;
    if (regs !== 16'h0010) begin errors++; $display("FAIL fl_ufl_regs got %h want 0010", regs); end
    checks++;
    if (tint !== 1'b1) begin errors++; $display("FAIL fl_ufl_tint got %b want 1", tint); end
  endtask

  task automatic test_zero_latch();
    step(1, 1, 1, 4'h4, 8'h00, mk(0, 0, 0, 0));
    step(1, 1, 1, 4'h5, 8'h00, mk(0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 4'h0, 8'h00, mk(1, 0, 0, 1));
      checks++;
      if (regs !== 16'h0000) begin
        errors++; $display("FAIL zero_regs step %0d got %h want 0000", i, regs);
      end
      if (i >= 1) begin
        checks++;
        if (ufl_obs !== 1'b1) begin
          errors++; $display("FAIL zero_ufl step %0d got %b want 1", i, ufl_obs);
        end
      end
    end
    step(0, 1, 0, 4'h0, 8'h00, mk(1, 0, 0, 1));
    checks++;
    if (regs !== 16'hFFFF) begin errors++; $display("FAIL midrst_regs got %h want ffff", regs); end
    checks++;
    if (tint !== 1'b0) begin errors++; $display("FAIL midrst_tint got %b want 0", tint); end
    checks++;
    if (ufl !== 1'b0) begin errors++; $display("FAIL midrst_ufl got %b want 0", ufl); end
  endtask

  task automatic test_random();
    tctrl_t c;
    logic   rn, phi, w;
    logic [3:0] a;
    for (int i = 0; i < 500; i++) begin
      rn  = ($urandom_range(0, 99) >= 2);
      phi = ($urandom_range(0, 3) != 0);
      w   = ($urandom_range(0, 7) == 0);
      a   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(4, 5)) : 4'($urandom_range(0, 15));
      c   = mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 7) != 0));
      step(rn, phi, w, a, 8'($urandom_range(0, 3)), c);
      checks++;
      if (ufl_obs !== m_ufl_pre) begin
        errors++; $display("FAIL rnd_ufl step %0d got %b want %b", i, ufl_obs, m_ufl_pre);
      end
      checks++;
      if (regs !== m_cnt) begin
        errors++; $display("FAIL rnd_regs step %0d got %h want %h", i, regs, m_cnt);
      end
      checks++;
      if (tint !== m_tint) begin
        errors++; $display("FAIL rnd_tint step %0d got %b want %b", i, tint, m_tint);
      end
      if (!c.toggle) begin
        checks++;
        if (pb_out !== m_tint) begin
          errors++; $display("FAIL rnd_pb step %0d got %b want %b", i, pb_out, m_tint);
        end
      end
    end
  endtask

  initial begin
    m_latch = 16'hFFFF; m_cnt = 16'hFFFF;
    m_cd = 0; m_tint = 0; m_tff = 0; m_sp = 0; m_ufl_pre = 0; ufl_obs = 0;
    test_reset();
    test_stopped_load();
    test_continuous();
    test_toggle();
    test_force_load();
    test_zero_latch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
